// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_pkg
// Purpose  : Shared constants and types for the rotate/shift datapath.
//            Also used by the shift_register benches for round-trip widths.
// Contents : SHIFT_WIDTH_DEFAULT  default word width
//            collector_state_e    deserializer collector FSM states
// Revision : 1.0  initial release
// ============================================================================
package shift_pkg;

   localparam int SHIFT_WIDTH_DEFAULT = 8;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,   // no partial word held
      COLLECT = 1'b1    // 0 < bit count < WIDTH
   } collector_state_e;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_deserializer_if
// Purpose  : Serial input strobe and parallel valid/ready output bundle of
//            the shift deserializer.
// Signals  : shift, ser_in, clr     serial side controls (master -> slave)
//            data_out, data_out_valid, data_out_ready   word handshake
//            bit_cnt, busy, overrun status (slave -> master)
// Modports : master = producer of bits / consumer of words (bench side)
//            slave  = the deserializer
// Revision : 1.0  initial release
// ============================================================================
interface shift_deserializer_if #(
   parameter int WIDTH = shift_pkg::SHIFT_WIDTH_DEFAULT
);
   localparam int CNT_W = $clog2(WIDTH);

   logic             shift;
   logic             ser_in;
   logic             clr;
   logic [WIDTH-1:0] data_out;
   logic             data_out_valid;
   logic             data_out_ready;
   logic [CNT_W-1:0] bit_cnt;
   logic             busy;
   logic             overrun;

   modport master (
      output shift, ser_in, clr, data_out_ready,
      input  data_out, data_out_valid, bit_cnt, busy, overrun
   );

   modport slave (
      input  shift, ser_in, clr, data_out_ready,
      output data_out, data_out_valid, bit_cnt, busy, overrun
   );

endinterface : shift_deserializer_if
`default_nettype wire

// File: rtl/shift_word_hold.sv
`default_nettype none
// ============================================================================
// Module   : shift_word_hold
// Purpose  : One-entry valid/ready holding register. A load is taken when
//            the entry is empty or is being consumed in the same cycle;
//            otherwise the incoming word is discarded and drop pulses.
// Ports    : clk, rst_n              clock, async active-low reset
//            load_valid, load_data   new word offered this cycle
//            out_ready               consumer accepts out_data
//            out_data, out_valid     held word and its valid flag
//            drop                    combinational: load_valid was refused
// Revision : 1.0  initial release
// ============================================================================
module shift_word_hold #(
   parameter int WIDTH = 8
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             load_valid,
   input  wire logic [WIDTH-1:0] load_data,
   input  wire logic             out_ready,
   output logic      [WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  drop
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      drop    = 1'b0;
      if (load_valid) begin
         if (!valid_q || out_ready) begin
            data_d  = load_data;
            valid_d = 1'b1;
         end else begin
            // Entry is full and stalled: keep the old word stable.
            drop = 1'b1;
         end
      end else if (valid_q && out_ready) begin
         // Data keeps its last value once consumed; only valid drops.
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;

endmodule : shift_word_hold
`default_nettype wire

// File: rtl/shift_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : shift_deserializer
// Purpose  : Serial-to-parallel receiver. One bit is taken per shift strobe;
//            every WIDTH bits form a word offered on a one-entry valid/ready
//            output. A sticky overrun flag records words dropped because the
//            output entry was still full.
// Ports    : clk    clock, all logic on posedge
//            rst_n  asynchronous active-low reset
//            bus    shift_deserializer_if.slave (shift, ser_in, clr,
//                   data_out/valid/ready, bit_cnt, busy, overrun)
// Params   : WIDTH      word width (>= 2)
//            MSB_FIRST  1: first bit lands in data_out[WIDTH-1]
//                       0: first bit lands in data_out[0]
// Revision : 1.0  initial release
// ============================================================================
module shift_deserializer #(
   parameter int WIDTH     = shift_pkg::SHIFT_WIDTH_DEFAULT,
   parameter bit MSB_FIRST = 1'b1
) (
   input wire logic            clk,
   input wire logic            rst_n,
   shift_deserializer_if.slave bus
);
   import shift_pkg::*;

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   collector_state_e state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [WIDTH-1:0] shifted;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             overrun_q, overrun_d;
   logic             take_bit;
   logic             last_bit;
   logic             word_done;
   logic             drop;

   // Shift direction fixes which end of the word the first bit ends up in.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign shifted = {sreg_q[WIDTH-2:0], bus.ser_in};
      end else begin : g_lsb_first
         assign shifted = {bus.ser_in, sreg_q[WIDTH-1:1]};
      end
   endgenerate

   // clr takes priority over a simultaneous strobe: that bit is discarded.
   assign take_bit  = bus.shift && !bus.clr;
   assign last_bit  = (bit_cnt_q == LAST_BIT);
   assign word_done = take_bit && last_bit;

   // Collector FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (take_bit) begin
               state_d = COLLECT;
            end
         end
         COLLECT: begin
            if (bus.clr || word_done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Collector datapath and sticky overrun
   always_comb begin
      sreg_d    = sreg_q;
      bit_cnt_d = bit_cnt_q;
      overrun_d = overrun_q | drop;
      if (bus.clr) begin
         sreg_d    = '0;
         bit_cnt_d = '0;
         overrun_d = 1'b0;
      end else if (bus.shift) begin
         if (last_bit) begin
            // The completed word leaves through the hold register.
            sreg_d    = '0;
            bit_cnt_d = '0;
         end else begin
            sreg_d    = shifted;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sreg_q    <= '0;
         bit_cnt_q <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sreg_q    <= sreg_d;
         bit_cnt_q <= bit_cnt_d;
         overrun_q <= overrun_d;
      end
   end

   shift_word_hold #(
      .WIDTH (WIDTH)
   ) u_word_hold (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (word_done),
      .load_data  (shifted),
      .out_ready  (bus.data_out_ready),
      .out_data   (bus.data_out),
      .out_valid  (bus.data_out_valid),
      .drop       (drop)
   );

   assign bus.bit_cnt = bit_cnt_q;
   assign bus.busy    = (state_q == COLLECT);
   assign bus.overrun = overrun_q;

endmodule : shift_deserializer
`default_nettype wire
